pipe_stage_buffer: RTL and testbench
====================================

// Module: pipe_stage_buffer
// PURPOSE
// - Parametrised successor to the fixed enable-tied pipeline flop used between pipeline stages.
// - Elastic inter-stage buffer: valid/ready handshake, DEPTH-entry storage, synchronous flush.
// - Lets a downstream stage stall, and lets the hazard logic squash a stage, without losing or duplicating payload.
// - One instance sits per stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.
// PARAMETERS
// - WIDTH      32  payload bits per entry (control bundle + datapath fields); >=1
// - DEPTH      2   entries of storage; >=1, need not be a power of two
// - CNT_W      $clog2(DEPTH+1)  occupancy width (derived, not overridden)
// PORTS
// - clk        in   1      rising-edge clock; sole clock domain
// - reset      in   1      asynchronous, active-low reset
// - in_valid   in   1      upstream stage presents payload
// - in_ready   out  1      buffer accepts payload this cycle
// - in_data    in   WIDTH  upstream payload
// - out_valid  out  1      head entry valid for downstream stage
// - out_ready  in   1      downstream stage consumes head this cycle
// - out_data   out  WIDTH  head entry payload
// - flush      in   1      synchronous squash of all held entries (branch taken / exception)
// - count      out  CNT_W  current occupancy, 0..DEPTH
// - stall_cnt  out  16     saturating stall-cycle counter (only with PIPE_STALL_STATS_EN)
// BEHAVIOUR
// - Reset (reset==0, async):
//   - count=0, wr_ptr=rd_ptr=0.
//   - out_valid=0, in_ready=1, out_data=0, stall_cnt=0.
//   - Storage contents are don't-care.
// - Handshakes:
//   - push = in_valid & in_ready.
//   - pop = out_valid & out_ready.
//   - Both are sampled on the rising clk edge.
// - Registered outputs:
//   - in_ready = (count != DEPTH).
//   - out_valid = (count != 0).
//   - Neither depends combinationally on in_valid, out_ready or flush.
// - out_data = mem[rd_ptr].
//   - Stable while out_valid=1 and out_ready=0.
//   - Is 0 while count==0.
// - Latency: a payload pushed at edge N is visible on out_data/out_valid after edge N. There is no bypass.
// - Throughput: 1 entry/cycle sustained when DEPTH>=2 and out_ready=1 continuously.
//   - DEPTH=1 gives at most 1 entry per 2 cycles when full, because in_ready=0 while full.
// - Pointers:
//   - Increment by 1 on push (wr_ptr) and on pop (rd_ptr).
//   - Wrap DEPTH-1 -> 0.
// - Occupancy update: count += push - pop.
//   - Simultaneous push and pop keeps count unchanged and advances both pointers.
// - Full (count==DEPTH): in_ready=0; in_valid is ignored and the upstream payload must be held.
// - Empty (count==0): out_valid=0; out_ready is ignored and no pointer moves.
// - Flush:
//   - Highest priority.
//   - At the edge where flush=1: count=0, wr_ptr=rd_ptr=0, and that cycle's push and pop are both discarded.
//   - The next cycle shows out_valid=0 and in_ready=1.
// - Reset asserted mid-transfer: all held entries are lost and the block returns to the reset state immediately.
// - No error or overflow state exists; the handshake rules prevent overflow and underflow.
// - State machine (derived from count):
//   - EMPTY -> PARTIAL on push.
//   - PARTIAL -> FULL on push without pop at count==DEPTH-1.
//   - FULL -> PARTIAL on pop.
//   - PARTIAL -> EMPTY on pop without push at count==1.
//   - Any -> EMPTY on flush.
//   - DEPTH=1 has no PARTIAL state.
// CONFIGURATION
// - `define PIPE_STALL_STATS_EN: adds stall_cnt.
//   - Increments on every cycle with out_valid=1 and out_ready=0.
//   - Saturates at 16'hFFFF.
//   - Unaffected by flush; cleared only by reset.
// - Without PIPE_STALL_STATS_EN: the stall_cnt port is absent and no counter logic is built. All other behaviour is identical.
// TESTING
// - Reset: reset=0 with in_valid=1 -> out_valid=0, in_ready=1, count=0, out_data=0. Release reset -> still empty until the first push.
// - Streaming: DEPTH=2, WIDTH=32, push 32'h0000_0001..32'h0000_0008 on back-to-back cycles with out_ready=1 -> 8 pops in order, 1-cycle latency, in_ready never 0.
// - Backpressure: out_ready=0, push A5A5_0001, A5A5_0002 -> count=2, in_ready=0, out_data=A5A5_0001. A third in_valid is held. Raise out_ready -> 0001, 0002, 0003 in order.
// - Simultaneous push/pop at count=1 -> count stays 1, head advances, no loss.
// - Wrap: DEPTH=3, push/pop 10 entries with random gaps -> order preserved across pointer wrap.
// - Flush: count=2 with flush=1, in_valid=1 and out_ready=1 on the same edge -> count=0 next cycle and neither entry is popped. The new payload is discarded. Next push is seen with 1-cycle latency.
// - Stats (PIPE_STALL_STATS_EN): out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; flush leaves it at 16'hFFFF.

Source files
------------

// File: rtl/pipe_stage_buffer.sv
// ---------------------------------------------------------------------------
// pipe_stage_buffer
//
// Elastic inter-stage pipeline buffer. It holds up to DEPTH payload words
// behind a valid/ready handshake, so a downstream stage can stall and the
// hazard logic can squash a stage without losing or duplicating payload.
// One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// Parameters
//   WIDTH   payload bits per entry (>=1)
//   DEPTH   storage entries (>=1, any value, not only powers of two)
//   CNT_W   occupancy width, derived from DEPTH
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   upstream presents payload
//   in_ready   buffer accepts payload this cycle (registered)
//   in_data    upstream payload
//   out_valid  head entry valid (registered)
//   out_ready  downstream consumes the head this cycle
//   out_data   head entry payload (registered, 0 while empty)
//   flush      synchronous squash of all held entries
//   count      current occupancy 0..DEPTH
//   stall_cnt  saturating stall-cycle counter (PIPE_STALL_STATS_EN only)
//
// Configuration macro: PIPE_STALL_STATS_EN adds the stall_cnt port and its
// counter. Without it the port and the counter are not built.
// ---------------------------------------------------------------------------
module pipe_stage_buffer #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] count
`ifdef PIPE_STALL_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             push_s;
  logic             pop_s;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign push_s = in_valid & in_ready_q;
  assign pop_s  = out_valid_q & out_ready;

  // Next-state for pointers, occupancy and the registered handshake outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Squash wins over any push or pop in the same cycle.
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    in_ready_d  = (count_d != CNT_FULL);
    out_valid_d = (count_d != {CNT_W{1'b0}});

    // The head after this edge may be the word being written right now
    // (push into an empty buffer, or push+pop at occupancy 1); storage
    // does not hold it yet, so forward it into the output register.
    if (count_d == {CNT_W{1'b0}}) begin
      out_data_d = {WIDTH{1'b0}};
    end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
      out_data_d = in_data;
    end else begin
      out_data_d = mem_q[rd_ptr_d];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Payload storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

`ifdef PIPE_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where the head is offered but not taken; saturate.
  always_comb begin
    if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;

  logic        clk;
  logic        reset;
  // DEPTH=2 instance
  logic        in_valid, out_ready, flush;
  logic [31:0] in_data;
  logic        in_ready2, out_valid2;
  logic [31:0] out_data2;
  logic [1:0]  count2;
  // DEPTH=3 instance
  logic        in_valid3, out_ready3, flush3;
  logic [31:0] in_data3;
  logic        in_ready3, out_valid3;
  logic [31:0] out_data3;
  logic [1:0]  count3;
`ifdef PIPE_STALL_STATS_EN
  logic [15:0] stall_cnt2, stall_cnt3;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] q2[$];
  logic [31:0] q3[$];
  logic acc3;

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .flush(flush), .count(count2)
`ifdef PIPE_STALL_STATS_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .flush(flush3), .count(count3)
`ifdef PIPE_STALL_STATS_EN
    , .stall_cnt(stall_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares the head against the scoreboard whenever a pop happens.
  always @(negedge clk) begin
    if (reset) begin
      if (!flush) begin
        if (out_valid2 && out_ready) begin
          if (q2.size() == 0) begin
            tests++; fails++;
            $display("FAIL d2_pop: got %h expected no entry", out_data2);
          end else begin
            check("d2_pop", out_data2, q2.pop_front());
          end
        end
        if (!out_valid2) check("d2_empty_data", out_data2, 32'h0);
      end
      if (!flush3) begin
        if (out_valid3 && out_ready3) begin
          if (q3.size() == 0) begin
            tests++; fails++;
            $display("FAIL d3_pop: got %h expected no entry", out_data3);
          end else begin
            check("d3_pop", out_data3, q3.pop_front());
          end
        end
        if (!out_valid3) check("d3_empty_data", out_data3, 32'h0);
      end
    end
  end

  // One clock cycle: inputs are already driven; record accepted pushes
  // into the scoreboards just after the monitor has run, then advance.
  task automatic tick();
    @(negedge clk);
    #1;
    if (flush) q2.delete();
    else if (in_valid && in_ready2) q2.push_back(in_data);
    acc3 = 1'b0;
    if (flush3) q3.delete();
    else if (in_valid3 && in_ready3) begin
      q3.push_back(in_data3);
      acc3 = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0; flush = 1'b0;
    in_valid3 = 1'b1; in_data3 = 32'hDEAD_BEEF; out_ready3 = 1'b0; flush3 = 1'b0;
    acc3 = 1'b0;

    // Reset state with in_valid asserted
    #12;
    check("rst_out_valid", {31'h0, out_valid2}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready2}, 32'h1);
    check("rst_count", {30'h0, count2}, 32'h0);
    check("rst_out_data", out_data2, 32'h0);
    check("rst3_in_ready", {31'h0, in_ready3}, 32'h1);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_valid3 = 1'b0;
    @(posedge clk); #1;
    tick();
    check("post_rst_out_valid", {31'h0, out_valid2}, 32'h0);
    check("post_rst_count", {30'h0, count2}, 32'h0);

    // Streaming, back-to-back with out_ready=1
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      check("stream_in_ready", {31'h0, in_ready2}, 32'h1);
      tick();
      check("stream_latency_valid", {31'h0, out_valid2}, 32'h1);
      check("stream_latency_data", out_data2, 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", {31'h0, out_valid2}, 32'h0);

    // Backpressure and simultaneous push/pop at count=1
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA5A5_0001; tick();
    in_data = 32'hA5A5_0002; tick();
    check("bp_count", {30'h0, count2}, 32'h2);
    check("bp_in_ready", {31'h0, in_ready2}, 32'h0);
    check("bp_head", out_data2, 32'hA5A5_0001);
    in_data = 32'hA5A5_0003; tick();
    check("bp_held_count", {30'h0, count2}, 32'h2);
    check("bp_held_head", out_data2, 32'hA5A5_0001);
    out_ready = 1'b1; tick();
    check("bp_pop_count", {30'h0, count2}, 32'h1);
    check("bp_pop_head", out_data2, 32'hA5A5_0002);
    tick();
    check("pushpop_count", {30'h0, count2}, 32'h1);
    check("pushpop_head", out_data2, 32'hA5A5_0003);
    in_valid = 1'b0; tick();
    check("bp_drained", {30'h0, count2}, 32'h0);

    // Flush with push and pop on the same edge
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hF000_0001; tick();
    in_data = 32'hF000_0002; tick();
    check("fl_pre_count", {30'h0, count2}, 32'h2);
    in_data = 32'hF000_0003; out_ready = 1'b1; flush = 1'b1; tick();
    flush = 1'b0;
    check("fl_count", {30'h0, count2}, 32'h0);
    check("fl_out_valid", {31'h0, out_valid2}, 32'h0);
    check("fl_in_ready", {31'h0, in_ready2}, 32'h1);
    check("fl_out_data", out_data2, 32'h0);
    in_data = 32'hF000_0004; out_ready = 1'b0; tick();
    check("fl_next_valid", {31'h0, out_valid2}, 32'h1);
    check("fl_next_data", out_data2, 32'hF000_0004);
    check("fl_next_count", {30'h0, count2}, 32'h1);
    in_valid = 1'b0; out_ready = 1'b1; tick();

    // Pointer wrap on DEPTH=3 with random gaps and random backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      int gap;
      bit done;
      gap = $urandom_range(0, 2);
      in_valid3 = 1'b0;
      for (int g = 0; g < gap; g++) begin
        out_ready3 = 1'($urandom_range(0, 1));
        tick();
      end
      in_valid3 = 1'b1; in_data3 = 32'h3000_0000 + 32'(k);
      done = 1'b0;
      for (int t = 0; t < 20 && !done; t++) begin
        out_ready3 = 1'($urandom_range(0, 1));
        tick();
        done = acc3;
      end
      if (!done) begin
        tests++; fails++;
        $display("FAIL wrap_accept: entry %0d not accepted in 20 cycles, expected accept", k);
      end
    end
    in_valid3 = 1'b0; out_ready3 = 1'b1;
    for (int t = 0; t < 20 && q3.size() != 0; t++) tick();
    tick();
    check("wrap_sb_empty", 32'(q3.size()), 32'h0);
    check("wrap_out_valid", {31'h0, out_valid3}, 32'h0);

`ifdef PIPE_STALL_STATS_EN
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5A5A_0001; tick();
    in_valid = 1'b0;
    for (int c = 0; c < 70000; c++) tick();
    check("stall_sat", {16'h0, stall_cnt2}, 32'h0000_FFFF);
    flush = 1'b1; tick(); flush = 1'b0;
    check("stall_after_flush", {16'h0, stall_cnt2}, 32'h0000_FFFF);
`endif

    // Reset asserted mid-transfer drops everything immediately
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7000_0001; tick();
    in_data = 32'h7000_0002; tick();
    in_valid = 1'b0;
    check("midrst_pre_count", {30'h0, count2}, 32'h2);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, out_valid2}, 32'h0);
    check("midrst_count", {30'h0, count2}, 32'h0);
    check("midrst_in_ready", {31'h0, in_ready2}, 32'h1);
    check("midrst_out_data", out_data2, 32'h0);
    q2.delete(); q3.delete();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    tick();
    check("midrst_still_empty", {31'h0, out_valid2}, 32'h0);
    check("final_sb2_empty", 32'(q2.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
